// File: rtl/cam_sync_array.sv
// rtl/cam_sync_array.sv - clocked binary CAM with alloc, invalidate, sequenced flush and 2-stage search
// Optional feature macro: CAM_TERNARY_EN (per-entry don't-care mask, adds wr_mask port)
module cam_sync_array #(
  parameter int WORD_SIZE   = 16,
  parameter int ROW_NUM     = 68,
  parameter int ENTRY_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ENTRY_WIDTH-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0]   wr_data,
`ifdef CAM_TERNARY_EN
  input  logic [WORD_SIZE-1:0]   wr_mask,
`endif
  input  logic                   alloc_en,
  output logic [ENTRY_WIDTH-1:0] alloc_addr,
  output logic                   full,
  input  logic                   inv_en,
  input  logic [ENTRY_WIDTH-1:0] inv_addr,
  input  logic                   flush,
  output logic                   busy,
  input  logic                   srch_en,
  input  logic [WORD_SIZE-1:0]   srch_data,
  output logic                   srch_vld,
  output logic                   srch_hit,
  output logic [ENTRY_WIDTH-1:0] srch_addr,
  output logic                   srch_multi
);

  typedef enum logic [0:0] {IDLE, FLUSH} state_t;

  localparam logic [ROW_NUM-1:0] MATCH_ONE = ROW_NUM'(1);

  state_t                 state_q, state_d;
  logic [ENTRY_WIDTH-1:0] flush_idx_q, flush_idx_d;
  logic [ROW_NUM-1:0]     valid_q, valid_d;
  logic [WORD_SIZE-1:0]   key_q [ROW_NUM];
  logic [WORD_SIZE-1:0]   key_d [ROW_NUM];
`ifdef CAM_TERNARY_EN
  logic [WORD_SIZE-1:0]   mask_q [ROW_NUM];
  logic [WORD_SIZE-1:0]   mask_d [ROW_NUM];
`endif

  logic                   s1_vld_q, s1_vld_d;
  logic [ROW_NUM-1:0]     s1_match_q, s1_match_d;
  logic                   srch_vld_q, srch_vld_d;
  logic                   srch_hit_q, srch_hit_d;
  logic [ENTRY_WIDTH-1:0] srch_addr_q, srch_addr_d;
  logic                   srch_multi_q, srch_multi_d;

  logic [ROW_NUM-1:0]     match;
  logic                   do_wr, do_alloc, do_inv;

  assign busy       = (state_q == FLUSH);
  assign full       = &valid_q;
  assign srch_vld   = srch_vld_q;
  assign srch_hit   = srch_hit_q;
  assign srch_addr  = srch_addr_q;
  assign srch_multi = srch_multi_q;

  // Lowest-index free slot; reads 0 when the array is full
  always_comb begin
    alloc_addr = '0;
    for (int i = ROW_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_addr = ENTRY_WIDTH'(i);
    end
  end

  // Entry update and flush sequencer; write beats invalidate, wr_en beats alloc_en
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    valid_d     = valid_q;
    key_d       = key_q;
`ifdef CAM_TERNARY_EN
    mask_d      = mask_q;
`endif
    do_wr    = wr_en && !busy;
    do_alloc = alloc_en && !wr_en && !full && !busy;
    do_inv   = inv_en && !busy;

    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end
      end
      FLUSH: begin
        if (flush_idx_q == ENTRY_WIDTH'(ROW_NUM - 1)) state_d = IDLE;
        else flush_idx_d = flush_idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < ROW_NUM; i++) begin
      if (busy && flush_idx_q == ENTRY_WIDTH'(i)) begin
        valid_d[i] = 1'b0;
        key_d[i]   = '0;
`ifdef CAM_TERNARY_EN
        mask_d[i]  = '0;
`endif
      end
      if (do_inv && inv_addr == ENTRY_WIDTH'(i)) valid_d[i] = 1'b0;
      if ((do_alloc && alloc_addr == ENTRY_WIDTH'(i)) ||
          (do_wr && wr_addr == ENTRY_WIDTH'(i))) begin
        valid_d[i] = 1'b1;
        key_d[i]   = wr_data;
`ifdef CAM_TERNARY_EN
        mask_d[i]  = wr_mask;
`endif
      end
    end
  end

  // Match vector against current contents; same-cycle updates are not visible
  always_comb begin
    for (int i = 0; i < ROW_NUM; i++) begin
`ifdef CAM_TERNARY_EN
      match[i] = valid_q[i] && (((key_q[i] ^ srch_data) & ~mask_q[i]) == '0);
`else
      match[i] = valid_q[i] && (key_q[i] == srch_data);
`endif
    end
  end

  // Two-stage search pipe: register match vector, then priority encode; results hold when idle
  always_comb begin
    s1_vld_d     = srch_en && !busy;
    s1_match_d   = s1_vld_d ? match : s1_match_q;
    srch_vld_d   = s1_vld_q;
    srch_hit_d   = srch_hit_q;
    srch_addr_d  = srch_addr_q;
    srch_multi_d = srch_multi_q;
    if (s1_vld_q) begin
      srch_hit_d   = |s1_match_q;
      srch_multi_d = |(s1_match_q & (s1_match_q - MATCH_ONE));
      srch_addr_d  = '0;
      for (int i = ROW_NUM - 1; i >= 0; i--) begin
        if (s1_match_q[i]) srch_addr_d = ENTRY_WIDTH'(i);
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      flush_idx_q  <= '0;
      valid_q      <= '0;
      for (int i = 0; i < ROW_NUM; i++) begin
        key_q[i]  <= '0;
`ifdef CAM_TERNARY_EN
        mask_q[i] <= '0;
`endif
      end
      s1_vld_q     <= 1'b0;
      s1_match_q   <= '0;
      srch_vld_q   <= 1'b0;
      srch_hit_q   <= 1'b0;
      srch_addr_q  <= '0;
      srch_multi_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_idx_q  <= flush_idx_d;
      valid_q      <= valid_d;
      key_q        <= key_d;
`ifdef CAM_TERNARY_EN
      mask_q       <= mask_d;
`endif
      s1_vld_q     <= s1_vld_d;
      s1_match_q   <= s1_match_d;
      srch_vld_q   <= srch_vld_d;
      srch_hit_q   <= srch_hit_d;
      srch_addr_q  <= srch_addr_d;
      srch_multi_q <= srch_multi_d;
    end
  end

endmodule

// File: tb/tb_cam_sync_array.sv
// tb/tb_cam_sync_array.sv - scoreboard bench for cam_sync_array
module tb_cam_sync_array;

  localparam int WS = 16;
  localparam int RN = 68;
  localparam int EW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [EW-1:0] wr_addr = '0;
  logic [WS-1:0] wr_data = '0;
`ifdef CAM_TERNARY_EN
  logic [WS-1:0] wr_mask = '0;
`endif
  logic          alloc_en = 1'b0;
  logic [EW-1:0] alloc_addr;
  logic          full;
  logic          inv_en = 1'b0;
  logic [EW-1:0] inv_addr = '0;
  logic          flush = 1'b0;
  logic          busy;
  logic          srch_en = 1'b0;
  logic [WS-1:0] srch_data = '0;
  logic          srch_vld;
  logic          srch_hit;
  logic [EW-1:0] srch_addr;
  logic          srch_multi;

  cam_sync_array #(.WORD_SIZE(WS), .ROW_NUM(RN), .ENTRY_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef CAM_TERNARY_EN
    .wr_mask(wr_mask),
`endif
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .full(full),
    .inv_en(inv_en), .inv_addr(inv_addr),
    .flush(flush), .busy(busy),
    .srch_en(srch_en), .srch_data(srch_data),
    .srch_vld(srch_vld), .srch_hit(srch_hit), .srch_addr(srch_addr), .srch_multi(srch_multi)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic          hit;
    logic [EW-1:0] addr;
    logic          multi;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: every presented search result must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && srch_vld) begin
      if (q.size() == 0) begin
        chk("unexpected_srch_vld", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("srch_latency", cyc, e.cyc + 2);
        chk("srch_hit", int'(srch_hit), int'(e.hit));
        chk("srch_addr", int'(srch_addr), int'(e.addr));
        chk("srch_multi", int'(srch_multi), int'(e.multi));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    wr_en = 1'b0; alloc_en = 1'b0; inv_en = 1'b0; flush = 1'b0; srch_en = 1'b0;
  endtask

  task automatic expect_srch(input logic [WS-1:0] key, input logic h, input int a, input logic m);
    exp_t e;
    srch_en   = 1'b1;
    srch_data = key;
    e.cyc = cyc; e.hit = h; e.addr = EW'(a); e.multi = m;
    q.push_back(e);
  endtask

  task automatic do_srch(input logic [WS-1:0] key, input logic h, input int a, input logic m);
    expect_srch(key, h, a, m);
    tick();
    clear_strobes();
  endtask

  task automatic do_wr(input int a, input logic [WS-1:0] d);
    wr_en = 1'b1; wr_addr = EW'(a); wr_data = d;
    tick();
    clear_strobes();
  endtask

  task automatic do_inv(input int a);
    inv_en = 1'b1; inv_addr = EW'(a);
    tick();
    clear_strobes();
  endtask

  initial begin
    int busy_cnt;
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_alloc_addr", int'(alloc_addr), 0);
    chk("reset_srch_vld", int'(srch_vld), 0);
    chk("reset_srch_hit", int'(srch_hit), 0);
    rst_n = 1'b1;
    tick();

    // zero key must not hit invalid zero-filled entries
    do_srch(16'h0000, 1'b0, 0, 1'b0);

    do_wr(5, 16'hBEEF);
    do_srch(16'hBEEF, 1'b1, 5, 1'b0);

    do_wr(9, 16'h1234);
    do_wr(3, 16'h1234);
    do_srch(16'h1234, 1'b1, 3, 1'b1);
    do_inv(3);
    do_srch(16'h1234, 1'b1, 9, 1'b0);

    // write and search in the same cycle: search sees old contents
    wr_en = 1'b1; wr_addr = 7'd7; wr_data = 16'hAAAA;
    expect_srch(16'hAAAA, 1'b0, 0, 1'b0);
    tick();
    clear_strobes();
    do_srch(16'hAAAA, 1'b1, 7, 1'b0);

    // out-of-range write is ignored
    do_wr(100, 16'h5555);
    do_srch(16'h5555, 1'b0, 0, 1'b0);

    // invalidate and write on the same entry: write wins
    inv_en = 1'b1; inv_addr = 7'd11;
    wr_en = 1'b1; wr_addr = 7'd11; wr_data = 16'h7777;
    tick();
    clear_strobes();
    do_srch(16'h7777, 1'b1, 11, 1'b0);

    // last entry, then idle cycles: result must hold
    do_wr(67, 16'hC0DE);
    do_srch(16'hC0DE, 1'b1, 67, 1'b0);
    tick(); tick(); tick();
    chk("hold_srch_addr", int'(srch_addr), 67);
    chk("hold_srch_hit", int'(srch_hit), 1);

    // flush; a search issued alongside the flush request still completes
    flush = 1'b1;
    expect_srch(16'hBEEF, 1'b1, 5, 1'b0);
    tick();
    clear_strobes();
    busy_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (busy) busy_cnt++;
      wr_en = busy; wr_addr = 7'd0; wr_data = 16'h4242;
      srch_en = busy; srch_data = 16'h4242;
      alloc_en = busy;
      flush = busy;
      tick();
      clear_strobes();
    end
    chk("flush_busy_cycles", busy_cnt, RN);
    chk("post_flush_busy", int'(busy), 0);
    chk("post_flush_full", int'(full), 0);
    do_srch(16'hBEEF, 1'b0, 0, 1'b0);
    do_srch(16'h4242, 1'b0, 0, 1'b0);
    do_srch(16'h7777, 1'b0, 0, 1'b0);

    // fill by allocation
    for (int i = 0; i < RN; i++) begin
      chk("alloc_addr_seq", int'(alloc_addr), i);
      alloc_en = 1'b1; wr_data = WS'(16'h1000 + i);
      tick();
      clear_strobes();
    end
    chk("full_after_fill", int'(full), 1);
    alloc_en = 1'b1; wr_data = 16'hFFFF;
    tick();
    clear_strobes();
    chk("full_after_extra_alloc", int'(full), 1);
    do_srch(16'hFFFF, 1'b0, 0, 1'b0);
    do_srch(16'h1028, 1'b1, 40, 1'b0);

    // alloc with wr_en in the same cycle: only the addressed write happens
    do_inv(20);
    chk("alloc_addr_after_inv", int'(alloc_addr), 20);
    chk("full_after_inv", int'(full), 0);
    alloc_en = 1'b1; wr_en = 1'b1; wr_addr = 7'd30; wr_data = 16'h9999;
    tick();
    clear_strobes();
    chk("alloc_addr_after_wr_alloc", int'(alloc_addr), 20);
    do_srch(16'h9999, 1'b1, 30, 1'b0);
    do_srch(16'h1014, 1'b0, 0, 1'b0);

`ifdef CAM_TERNARY_EN
    wr_en = 1'b1; wr_addr = 7'd2; wr_data = 16'h12F0; wr_mask = 16'h00FF;
    tick();
    clear_strobes();
    wr_mask = '0;
    do_srch(16'h1234, 1'b1, 2, 1'b0);
`endif

    repeat (5) tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
